// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-port, byte-strobed data RAM between the core
// load/store path (m0) and a DMA/debug port (m1). Each accepted request runs
// IDLE -> ACCESS -> RESP, with fault detection, byte-lane steering on stores
// and sign/zero extension on loads.
module dmem_arbiter #(
  parameter int RAM_DEPTH_WORDS = 64,
  parameter bit FAIR            = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [1:0]  m0_size,
  input  logic        m0_unsigned,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [1:0]  m1_size,
  input  logic        m1_unsigned,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  output logic [3:0]  ram_wstrb,
  output logic        ram_st_misaligned,
  input  logic [31:0] ram_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  localparam logic [32:0] ADDR_LIMIT = 33'(RAM_DEPTH_WORDS * 4);

  state_t      r_state;
  logic        r_last;
  logic        r_owner;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [1:0]  r_size;
  logic        r_uns;
  logic [31:0] r_rdata;
  logic        r_err;

  logic        w_idle, w_access, w_resp, w_any, w_pick1;
  logic        w_sel_we, w_sel_uns;
  logic [31:0] w_sel_addr, w_sel_wdata;
  logic [1:0]  w_sel_size;
  logic        w_mis, w_ill, w_rng, w_fault;

  // Byte strobes for an access of the given size at the given lane offset.
  function automatic logic [3:0] lane_strb(input logic [1:0] size, input logic [1:0] ofs);
    case (size)
      2'b00:   lane_strb = 4'b0001 << ofs;
      2'b01:   lane_strb = 4'b0011 << ofs;
      2'b10:   lane_strb = 4'b1111;
      default: lane_strb = 4'b0000;
    endcase
  endfunction

  // Replicate right-aligned store data across every lane it could land in.
  function automatic logic [31:0] lane_wdata(input logic [31:0] wd, input logic [1:0] size);
    case (size)
      2'b00:   lane_wdata = {4{wd[7:0]}};
      2'b01:   lane_wdata = {2{wd[15:0]}};
      default: lane_wdata = wd;
    endcase
  endfunction

  // Pick the addressed lane out of the RAM word and extend it to 32 bits.
  function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [1:0] ofs,
                                           input logic [1:0] size, input logic uns);
    logic signed [7:0]  sb;
    logic signed [15:0] sh;
    sb = word[{ofs, 3'b000} +: 8];
    sh = ofs[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   load_ext = uns ? {24'd0, sb} : 32'(sb);
      2'b01:   load_ext = uns ? {16'd0, sh} : 32'(sh);
      default: load_ext = word;
    endcase
  endfunction

  assign w_idle   = (r_state == S_IDLE);
  assign w_access = (r_state == S_ACCESS);
  assign w_resp   = (r_state == S_RESP);

  // m1 wins when alone, or on a tie under round-robin when m0 was granted last.
  assign w_any   = m0_req | m1_req;
  assign w_pick1 = m1_req & (~m0_req | (FAIR & ~r_last));
  assign m0_gnt  = w_idle & m0_req & ~w_pick1;
  assign m1_gnt  = w_idle & w_pick1;

  assign w_sel_we    = w_pick1 ? m1_we       : m0_we;
  assign w_sel_addr  = w_pick1 ? m1_addr     : m0_addr;
  assign w_sel_wdata = w_pick1 ? m1_wdata    : m0_wdata;
  assign w_sel_size  = w_pick1 ? m1_size     : m0_size;
  assign w_sel_uns   = w_pick1 ? m1_unsigned : m0_unsigned;

  assign w_mis   = ((r_size == 2'b01) & r_addr[0]) | ((r_size == 2'b10) & (r_addr[1:0] != 2'b00));
  assign w_ill   = (r_size == 2'b11);
  assign w_rng   = ({1'b0, r_addr} >= ADDR_LIMIT);
  assign w_fault = w_mis | w_ill | w_rng;

  // Write controls are decoded from state so a reset drops them without a clock.
  assign ram_we            = w_access & r_we & ~w_fault;
  assign ram_wstrb         = ram_we ? lane_strb(r_size, r_addr[1:0]) : 4'b0000;
  assign ram_st_misaligned = w_access & r_we & w_mis;
  assign ram_addr          = r_addr;
  assign ram_wdata         = lane_wdata(r_wdata, r_size);

  assign m0_rvalid = w_resp & ~r_owner;
  assign m1_rvalid = w_resp &  r_owner;
  assign m0_rdata  = m0_rvalid ? r_rdata : 32'd0;
  assign m1_rdata  = m1_rvalid ? r_rdata : 32'd0;
  assign m0_err    = m0_rvalid & r_err;
  assign m1_err    = m1_rvalid & r_err;

  // Access sequencer: latch the winner, perform the RAM cycle, then respond.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_last  <= 1'b1;
      r_owner <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_size  <= 2'b00;
      r_uns   <= 1'b0;
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_owner <= w_pick1;
            r_last  <= w_pick1;
            r_we    <= w_sel_we;
            r_addr  <= w_sel_addr;
            r_wdata <= w_sel_wdata;
            r_size  <= w_sel_size;
            r_uns   <= w_sel_uns;
            r_state <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          r_err   <= w_fault;
          r_rdata <= (w_fault | r_we) ? 32'd0 : load_ext(ram_rdata, r_addr[1:0], r_size, r_uns);
          r_state <= S_RESP;
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a round-robin instance (u_rr) backed by a
// byte-strobed RAM model, and a fixed-priority instance (u_fp) on a constant
// read word.
module tb_dmem_arbiter;

  logic clk, reset_n;

  logic        m0_req, m0_we, m0_unsigned, m0_gnt, m0_rvalid, m0_err;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic [1:0]  m0_size;
  logic        m1_req, m1_we, m1_unsigned, m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic [1:0]  m1_size;
  logic        ram_we, ram_st_misaligned;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;
  logic [3:0]  ram_wstrb;

  logic        f0_req, f0_gnt, f0_rvalid, f0_err;
  logic [31:0] f0_rdata;
  logic        f1_req, f1_gnt, f1_rvalid, f1_err;
  logic [31:0] f1_rdata;
  logic        fram_we, fram_mis;
  logic [31:0] fram_addr, fram_wdata;
  logic [3:0]  fram_wstrb;
  logic [31:0] fram_rdata;

  logic [31:0] mem [64];

  int n_vec = 0;
  int n_err = 0;

  dmem_arbiter #(.RAM_DEPTH_WORDS(64), .FAIR(1'b1)) u_rr (
    .clk(clk), .reset_n(reset_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_size(m0_size), .m0_unsigned(m0_unsigned), .m0_gnt(m0_gnt),
    .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_size(m1_size), .m1_unsigned(m1_unsigned), .m1_gnt(m1_gnt),
    .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_wstrb(ram_wstrb), .ram_st_misaligned(ram_st_misaligned), .ram_rdata(ram_rdata)
  );

  dmem_arbiter #(.RAM_DEPTH_WORDS(64), .FAIR(1'b0)) u_fp (
    .clk(clk), .reset_n(reset_n),
    .m0_req(f0_req), .m0_we(1'b0), .m0_addr(32'h0000_0000), .m0_wdata(32'd0),
    .m0_size(2'b10), .m0_unsigned(1'b0), .m0_gnt(f0_gnt),
    .m0_rvalid(f0_rvalid), .m0_rdata(f0_rdata), .m0_err(f0_err),
    .m1_req(f1_req), .m1_we(1'b0), .m1_addr(32'h0000_0004), .m1_wdata(32'd0),
    .m1_size(2'b10), .m1_unsigned(1'b0), .m1_gnt(f1_gnt),
    .m1_rvalid(f1_rvalid), .m1_rdata(f1_rdata), .m1_err(f1_err),
    .ram_we(fram_we), .ram_addr(fram_addr), .ram_wdata(fram_wdata),
    .ram_wstrb(fram_wstrb), .ram_st_misaligned(fram_mis), .ram_rdata(fram_rdata)
  );

  assign fram_rdata = 32'hCAFE_F00D;
  assign ram_rdata  = mem[ram_addr[7:2]];

  initial begin
    clk = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = 32'd0;
  end

  always #5 clk = ~clk;

  // RAM model: strobed byte writes, suppressed while the misaligned flag is up.
  always @(posedge clk) begin
    if (ram_we && !ram_st_misaligned)
      for (int i = 0; i < 4; i++)
        if (ram_wstrb[i]) mem[ram_addr[7:2]][8*i +: 8] <= ram_wdata[8*i +: 8];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // One complete transaction on u_rr from port p, checking every phase.
  task automatic txn(input string tag, input bit p, input logic we, input logic [31:0] addr,
                     input logic [31:0] wd, input logic [1:0] size, input logic uns,
                     input logic [3:0] e_strb, input logic e_mis, input logic [31:0] e_wd,
                     input logic [31:0] e_rd, input logic e_err);
    @(negedge clk);
    if (!p) begin
      m0_we = we; m0_addr = addr; m0_wdata = wd; m0_size = size; m0_unsigned = uns; m0_req = 1'b1;
    end else begin
      m1_we = we; m1_addr = addr; m1_wdata = wd; m1_size = size; m1_unsigned = uns; m1_req = 1'b1;
    end
    #1;
    chk({tag, ".gnt"}, {30'd0, m1_gnt, m0_gnt}, p ? 32'd2 : 32'd1);
    @(negedge clk);
    m0_req = 1'b0; m1_req = 1'b0;
    #1;
    chk({tag, ".ram_we"}, {31'd0, ram_we}, {31'd0, |e_strb});
    chk({tag, ".wstrb"}, {28'd0, ram_wstrb}, {28'd0, e_strb});
    chk({tag, ".st_mis"}, {31'd0, ram_st_misaligned}, {31'd0, e_mis});
    chk({tag, ".ram_addr"}, ram_addr, addr);
    if (|e_strb) chk({tag, ".wdata"}, ram_wdata, e_wd);
    @(negedge clk);
    #1;
    chk({tag, ".rvalid"}, {30'd0, m1_rvalid, m0_rvalid}, p ? 32'd2 : 32'd1);
    chk({tag, ".rdata"}, p ? m1_rdata : m0_rdata, e_rd);
    chk({tag, ".err"}, {31'd0, p ? m1_err : m0_err}, {31'd0, e_err});
    chk({tag, ".other"}, p ? m0_rdata : m1_rdata, 32'd0);
  endtask

  initial begin
    bit own;
    reset_n = 1'b0;
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0; m0_size = 0; m0_unsigned = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0; m1_size = 0; m1_unsigned = 0;
    f0_req = 0; f1_req = 0;
    #1;
    chk("reset.gnt_rvalid_err", {26'd0, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err}, 32'd0);
    chk("reset.rdata", m0_rdata | m1_rdata, 32'd0);
    chk("reset.ram_ctl", {26'd0, ram_we, ram_st_misaligned, ram_wstrb}, 32'd0);
    chk("reset.ram_addr", ram_addr, 32'd0);
    chk("reset.ram_wdata", ram_wdata, 32'd0);
    #20;
    @(negedge clk);
    reset_n = 1'b1;

    // Word store then load on m0.
    txn("st_word", 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 2'b10, 1'b0, 4'b1111, 1'b0, 32'hDEAD_BEEF, 32'd0, 1'b0);
    txn("ld_word", 1'b0, 1'b0, 32'h10, 32'd0, 2'b10, 1'b0, 4'b0000, 1'b0, 32'd0, 32'hDEAD_BEEF, 1'b0);
    // Byte and half lanes with extension on m1.
    txn("st_byte", 1'b1, 1'b1, 32'h21, 32'hABCD_EF80, 2'b00, 1'b0, 4'b0010, 1'b0, 32'h8080_8080, 32'd0, 1'b0);
    txn("ld_sbyte", 1'b1, 1'b0, 32'h21, 32'd0, 2'b00, 1'b0, 4'b0000, 1'b0, 32'd0, 32'hFFFF_FF80, 1'b0);
    txn("ld_ubyte", 1'b1, 1'b0, 32'h21, 32'd0, 2'b00, 1'b1, 4'b0000, 1'b0, 32'd0, 32'h0000_0080, 1'b0);
    txn("st_half", 1'b1, 1'b1, 32'h22, 32'h5555_8001, 2'b01, 1'b0, 4'b1100, 1'b0, 32'h8001_8001, 32'd0, 1'b0);
    txn("ld_shalf", 1'b1, 1'b0, 32'h22, 32'd0, 2'b01, 1'b0, 4'b0000, 1'b0, 32'd0, 32'hFFFF_8001, 1'b0);
    txn("ld_uhalf", 1'b1, 1'b0, 32'h22, 32'd0, 2'b01, 1'b1, 4'b0000, 1'b0, 32'd0, 32'h0000_8001, 1'b0);
    // Faults.
    txn("st_misal", 1'b0, 1'b1, 32'h13, 32'h1234_5678, 2'b10, 1'b0, 4'b0000, 1'b1, 32'd0, 32'd0, 1'b1);
    txn("ld_after_misal", 1'b0, 1'b0, 32'h10, 32'd0, 2'b10, 1'b0, 4'b0000, 1'b0, 32'd0, 32'hDEAD_BEEF, 1'b0);
    txn("ld_range", 1'b0, 1'b0, 32'h100, 32'd0, 2'b10, 1'b0, 4'b0000, 1'b0, 32'd0, 32'd0, 1'b1);
    txn("ld_misal_half", 1'b0, 1'b0, 32'h21, 32'd0, 2'b01, 1'b0, 4'b0000, 1'b0, 32'd0, 32'd0, 1'b1);
    txn("st_illegal", 1'b1, 1'b1, 32'h20, 32'hFFFF_FFFF, 2'b11, 1'b0, 4'b0000, 1'b0, 32'd0, 32'd0, 1'b1);
    txn("ld_illegal", 1'b1, 1'b0, 32'h20, 32'd0, 2'b11, 1'b0, 4'b0000, 1'b0, 32'd0, 32'd0, 1'b1);
    txn("ld_after_illegal", 1'b1, 1'b0, 32'h20, 32'd0, 2'b10, 1'b0, 4'b0000, 1'b0, 32'd0, 32'h8001_8000, 1'b0);

    // Round-robin contention: m1 was granted last, so m0 takes the first tie.
    @(negedge clk);
    m0_we = 0; m0_addr = 32'h10; m0_size = 2'b10; m0_unsigned = 0; m0_req = 1'b1;
    m1_we = 0; m1_addr = 32'h20; m1_size = 2'b10; m1_unsigned = 0; m1_req = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      own = (((k / 3) % 2) == 1);
      case (k % 3)
        0: chk("rr.gnt", {30'd0, m1_gnt, m0_gnt}, own ? 32'd2 : 32'd1);
        1: chk("rr.quiet", {29'd0, m1_gnt, m0_gnt, m1_rvalid | m0_rvalid}, 32'd0);
        default: begin
          chk("rr.rvalid", {30'd0, m1_rvalid, m0_rvalid}, own ? 32'd2 : 32'd1);
          chk("rr.rdata", own ? m1_rdata : m0_rdata, own ? 32'h8001_8000 : 32'hDEAD_BEEF);
        end
      endcase
    end
    @(negedge clk);
    m0_req = 1'b0; m1_req = 1'b0;

    // Reset during the ACCESS cycle of an m0 store.
    @(negedge clk);
    m0_we = 1; m0_addr = 32'h30; m0_wdata = 32'h55AA_55AA; m0_size = 2'b10; m0_req = 1'b1;
    #1;
    chk("rst.gnt", {30'd0, m1_gnt, m0_gnt}, 32'd1);
    @(negedge clk);
    m0_req = 1'b0;
    #1;
    chk("rst.we_before", {31'd0, ram_we}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("rst.we_async", {28'd0, ram_we, ram_wstrb[2:0]}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("rst.no_rvalid", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
      @(negedge clk);
    end
    m0_we = 0; m0_addr = 32'h30; m0_size = 2'b10; m0_req = 1'b1;
    m1_we = 0; m1_addr = 32'h20; m1_size = 2'b10; m1_req = 1'b1;
    #1;
    chk("rst.first_tie", {30'd0, m1_gnt, m0_gnt}, 32'd1);
    @(negedge clk);
    m0_req = 1'b0; m1_req = 1'b0;
    @(negedge clk);
    #1;
    chk("rst.rvalid", {30'd0, m1_rvalid, m0_rvalid}, 32'd1);
    chk("rst.word_unchanged", m0_rdata, 32'd0);

    // Fixed priority: m0 wins every tie and m1 starves until m0 drops.
    @(negedge clk);
    f0_req = 1'b1; f1_req = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      if (k % 3 == 0) chk("fp.gnt", {30'd0, f1_gnt, f0_gnt}, 32'd1);
      if (k % 3 == 2) begin
        chk("fp.rvalid", {30'd0, f1_rvalid, f0_rvalid}, 32'd1);
        chk("fp.rdata", f0_rdata, 32'hCAFE_F00D);
      end
    end
    @(negedge clk);
    f0_req = 1'b0;
    #1;
    chk("fp.m1_gnt", {30'd0, f1_gnt, f0_gnt}, 32'd2);
    @(negedge clk);
    f1_req = 1'b0;
    @(negedge clk);
    #1;
    chk("fp.m1_rvalid", {30'd0, f1_rvalid, f0_rvalid}, 32'd2);
    chk("fp.m1_rdata", f1_rdata, 32'hCAFE_F00D);
    chk("fp.m1_err", {31'd0, f1_err}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

- Two-port arbiter and access sequencer for the single-port data RAM (64 words, byte-strobed writes, combinational read).
- Shares the RAM between requester 0 (core load/store path) and requester 1 (DMA/debug port).
- Generates byte strobes and lane-replicated write data, detects misaligned, illegal-size and out-of-range accesses, and returns sign- or zero-extended load data.
- Every accepted request completes in a fixed 3-cycle sequence.

## Interface

Parameters:
- RAM_DEPTH_WORDS, 64, RAM size in words; accesses with addr >= RAM_DEPTH_WORDS*4 are out of range.
- FAIR, 1, 1 = round-robin arbitration; 0 = fixed priority, requester 0 wins.

Ports:
- Clock/reset: one clock; reset is asynchronous and active-low.
  - clk  in  1  clock, all state updates on the rising edge.
  - reset_n  in  1  asynchronous, active-low reset.
- Requester ports, x = 0 or 1:
  - mx_req  in  1  request; held with its fields stable until mx_gnt.
  - mx_we  in  1  1 = store, 0 = load.
  - mx_addr  in  32  byte address.
  - mx_wdata  in  32  store data, right-aligned.
  - mx_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
  - mx_unsigned  in  1  load zero-extension select.
  - mx_gnt  out  1  request accepted this cycle.
  - mx_rvalid  out  1  one-cycle completion pulse, for loads and stores.
  - mx_rdata  out  32  extended load data, valid with rvalid; 0 for stores and errors.
  - mx_err  out  1  access faulted, valid with rvalid.
- RAM port:
  - ram_we  out  1  write enable.
  - ram_addr  out  32  byte address to the RAM.
  - ram_wdata  out  32  lane-replicated store data.
  - ram_wstrb  out  4  byte strobes.
  - ram_st_misaligned  out  1  misaligned-store flag; the RAM suppresses writes when it is high.
  - ram_rdata  in  32  combinational read word.

## Operation

FSM states: IDLE, ACCESS, RESP.

- **IDLE**
  - If any mx_req is high, pick a winner and assert its mx_gnt combinationally.
  - Latch the winner's we, addr, wdata, size, unsigned and owner id; go to ACCESS.
  - No request: stay in IDLE.
- **Arbitration**
  - FAIR=1: on a tie, the requester not granted last wins. The last-grant register resets to 1, so requester 0 wins the first tie.
  - FAIR=0: requester 0 always wins.
  - A single requester always wins.
- **ACCESS**
  - ram_addr is the latched address.
  - Fault detection:
    - misaligned: half with addr[0]=1, or word with addr[1:0]!=00.
    - illegal: size 11.
    - range: addr >= RAM_DEPTH_WORDS*4.
  - Store, no fault:
    - ram_we=1.
    - ram_wstrb: byte = 0001<<addr[1:0]; half = 0011<<addr[1:0]; word = 1111.
    - ram_wdata: byte = {4{wdata[7:0]}}; half = {2{wdata[15:0]}}; word = wdata.
  - Store with any fault: ram_we=0, ram_wstrb=0. ram_st_misaligned=1 for the misaligned case only.
  - Load:
    - ram_we=0.
    - Select lane addr[1:0] (byte) or addr[1] (half).
    - Sign-extend, or zero-extend when unsigned; capture into the response register at the clock edge.
  - Any fault: response data is 0 and the error flag is set. Go to RESP.
- **RESP**
  - Owner's mx_rvalid=1 for exactly one cycle, with mx_rdata and mx_err. Go to IDLE.
  - The non-owner's rvalid, rdata and err stay 0.
- **Requests arriving in ACCESS or RESP** are neither granted nor lost. They are arbitrated in the next IDLE, provided the requester keeps req high.
- **Reset**, including mid-operation: FSM goes to IDLE immediately and last-grant goes to 1. A write in ACCESS is aborted because ram_we drops asynchronously.

## Timing

- Request sampled high in IDLE cycle N:
  - mx_gnt high in cycle N.
  - ACCESS and RAM write in cycle N+1; the write commits at the end-of-N+1 edge.
  - mx_rvalid high in cycle N+2.
  - Next grant possible in cycle N+3.
  - Peak throughput: one access per 3 cycles.
- mx_gnt is high only in IDLE, and for at most one requester.
- ram_we, ram_wstrb and ram_st_misaligned are 0 outside ACCESS. ram_addr and ram_wdata hold their last values.
- Reset values (all outputs): mx_gnt 0, mx_rvalid 0, mx_rdata 0, mx_err 0, ram_we 0, ram_addr 0, ram_wdata 0, ram_wstrb 0, ram_st_misaligned 0.

## Test plan

- **Word store then load (m0):** store word 0xDEADBEEF to 0x10, then load word from 0x10 → store: gnt, then wstrb=1111, then rvalid, err=0. Load: rdata=0xDEADBEEF, rvalid at N+2.
- **Byte/half load extension (m1):** store byte 0x80 to 0x21 → wstrb=0010, wdata=0x80808080. Then:
  - signed byte load from 0x21 → 0xFFFFFF80.
  - unsigned byte load from 0x21 → 0x00000080.
  - half store 0x8001 to 0x22 → wstrb=1100.
  - signed half load from 0x22 → 0xFFFF8001.
- **Faults:**
  - word store to 0x13 → ram_we=0, ram_st_misaligned=1, err=1; memory unchanged on readback.
  - word load from 0x100 → err=1, rdata=0.
  - size=11 → err=1.
- **Contention, FAIR=1:** m0 and m1 request continuously for 4 transactions → grants alternate m0, m1, m0, m1, spaced 3 cycles apart; each rvalid goes only to its owner.
- **Fixed priority:** FAIR=0, same stimulus → m0 granted every time and m1 starves. Then drop m0_req → m1 is granted in the next IDLE.
- **Reset mid-operation:** assert reset_n=0 during the ACCESS cycle of a store → ram_we falls without a clock, the target word is unchanged, and no rvalid is seen. After release, m0 wins the first simultaneous request.
